// File: rtl/rv32i_types.sv
// Shared types for the rv32i memory stage: scheduler state encoding and
// starvation defaults used by dmem_sched and its helpers.
package rv32i_types;

  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_WAIT  = 2'd1,
    ST_WAIT  = 2'd2,
    LD_DRAIN = 2'd3
  } dmem_state_e;

  // Width needed to hold a count from 0 up to and including limit.
  function automatic int ctr_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dmem_starve_ctr.sv
// Counts store grants issued while a load is waiting; sat tells the
// scheduler that the waiting load must be issued next.
module dmem_starve_ctr
  import rv32i_types::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = ctr_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] count;

  // Clear wins over increment; increment sticks at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign sat = (count == LIMIT);

endmodule

// File: rtl/dmem_sched.sv
// Data-memory scheduler: arbitrates the load RS against the committed store
// buffer, keeping a single dmem access outstanding at a time.
module dmem_sched
  import rv32i_types::*;
#(
  parameter int LOAD_RS_DEPTH = 3,
  parameter int STARVE_LIMIT  = STARVE_LIMIT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     ld_req,
  input  logic [LOAD_RS_DEPTH-1:0] ld_idx,
  input  logic [31:0]              ld_addr,
  input  logic [3:0]               ld_rmask,
  input  logic                     st_req,
  input  logic [31:0]              st_addr,
  input  logic [3:0]               st_wmask,
  input  logic [31:0]              st_wdata,
  output logic                     ld_grant,
  output logic                     st_grant,
  output logic [31:0]              dmem_addr,
  output logic [3:0]               dmem_rmask,
  output logic [3:0]               dmem_wmask,
  output logic [31:0]              dmem_wdata,
  input  logic [31:0]              dmem_rdata,
  input  logic                     dmem_resp,
  output logic                     ld_done,
  output logic [LOAD_RS_DEPTH-1:0] ld_done_idx,
  output logic [31:0]              ld_rdata,
  output logic                     st_pop,
  output logic                     busy
);

  dmem_state_e state;
  dmem_state_e state_next;

  logic                     starve_sat;
  logic                     ld_go;
  logic                     st_go;
  logic                     starve_inc;
  logic                     starve_clr;
  logic [31:0]              lat_addr;
  logic [31:0]              lat_wdata;
  logic [3:0]               lat_rmask;
  logic [3:0]               lat_wmask;
  logic [LOAD_RS_DEPTH-1:0] lat_idx;

  // A load wins when no store competes or the store stream has starved it.
  assign ld_go = (state == IDLE) && ld_req && !flush && (!st_req || starve_sat);
  assign st_go = (state == IDLE) && st_req && !ld_go;

  assign starve_inc = st_go && ld_req;
  assign starve_clr = ld_go || ((state == IDLE) && !ld_req);

  dmem_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk(clk),
    .rst(rst),
    .inc(starve_inc),
    .clr(starve_clr),
    .sat(starve_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ld_go) begin
          state_next = LD_WAIT;
        end else if (st_go) begin
          state_next = ST_WAIT;
        end
      end
      LD_WAIT: begin
        if (dmem_resp) begin
          state_next = IDLE;
        end else if (flush) begin
          state_next = LD_DRAIN;
        end
      end
      LD_DRAIN: begin
        if (dmem_resp) begin
          state_next = IDLE;
        end
      end
      ST_WAIT: begin
        if (dmem_resp) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latches; the unused half of each access is zeroed so the
  // dmem bus never carries stale data from the previous access type.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_rmask <= '0;
      lat_wmask <= '0;
      lat_idx   <= '0;
    end else if (ld_go) begin
      lat_addr  <= ld_addr;
      lat_rmask <= ld_rmask;
      lat_idx   <= ld_idx;
      lat_wmask <= '0;
      lat_wdata <= '0;
    end else if (st_go) begin
      lat_addr  <= st_addr;
      lat_wmask <= st_wmask;
      lat_wdata <= st_wdata;
      lat_rmask <= '0;
    end
  end

  // Outputs are forced low while reset is held, including the grants that
  // would otherwise follow the request inputs combinationally.
  always_comb begin
    ld_grant    = 1'b0;
    st_grant    = 1'b0;
    dmem_addr   = '0;
    dmem_rmask  = '0;
    dmem_wmask  = '0;
    dmem_wdata  = '0;
    ld_done     = 1'b0;
    ld_done_idx = '0;
    ld_rdata    = '0;
    st_pop      = 1'b0;
    busy        = 1'b0;
    if (rst) begin
      busy = (state != IDLE);
      case (state)
        IDLE: begin
          ld_grant = ld_go;
          st_grant = st_go;
        end
        LD_WAIT: begin
          dmem_addr  = lat_addr;
          dmem_rmask = lat_rmask;
          if (dmem_resp && !flush) begin
            ld_done     = 1'b1;
            ld_done_idx = lat_idx;
            ld_rdata    = dmem_rdata;
          end
        end
        LD_DRAIN: begin
          dmem_addr  = lat_addr;
          dmem_rmask = lat_rmask;
        end
        ST_WAIT: begin
          dmem_addr  = lat_addr;
          dmem_wmask = lat_wmask;
          dmem_wdata = lat_wdata;
          st_pop     = dmem_resp;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_sched.sv
// Scoreboard bench for dmem_sched: a transaction-level model predicts grant,
// completion and pop events plus the dmem bus contents for every cycle.
module tb_dmem_sched;

  localparam int IDXW   = 3;
  localparam int LIMIT  = 4;
  localparam int K_LDG  = 1;
  localparam int K_STG  = 2;
  localparam int K_DONE = 3;
  localparam int K_POP  = 4;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] idx;
    logic [31:0] data;
  } exp_ev_t;

  exp_ev_t exp_q[$];

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic            ld_req = 1'b0;
  logic [IDXW-1:0] ld_idx = '0;
  logic [31:0]     ld_addr = '0;
  logic [3:0]      ld_rmask = '0;
  logic            st_req = 1'b0;
  logic [31:0]     st_addr = '0;
  logic [3:0]      st_wmask = '0;
  logic [31:0]     st_wdata = '0;
  logic [31:0]     dmem_rdata = '0;
  logic            dmem_resp = 1'b0;
  logic            ld_grant;
  logic            st_grant;
  logic [31:0]     dmem_addr;
  logic [3:0]      dmem_rmask;
  logic [3:0]      dmem_wmask;
  logic [31:0]     dmem_wdata;
  logic            ld_done;
  logic [IDXW-1:0] ld_done_idx;
  logic [31:0]     ld_rdata;
  logic            st_pop;
  logic            busy;

  int cycle = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  // Reference model: kind of access in flight (0 none, 1 load, 2 store).
  int              m_kind = 0;
  int              m_age = 0;
  bit              m_squash = 1'b0;
  int              m_starve = 0;
  logic [31:0]     m_addr = '0;
  logic [31:0]     m_wdata = '0;
  logic [3:0]      m_rmask = '0;
  logic [3:0]      m_wmask = '0;
  logic [IDXW-1:0] m_idx = '0;
  int              lat = 1;
  bit              spurious_resp = 1'b0;

  logic [IDXW-1:0] pend_ld_idx = '0;
  logic [31:0]     pend_ld_addr = '0;
  logic [3:0]      pend_ld_rmask = '0;
  logic [31:0]     pend_st_addr = '0;
  logic [3:0]      pend_st_wmask = '0;
  logic [31:0]     pend_st_wdata = '0;
  logic [31:0]     pend_rdata = '0;

  bit          exp_busy = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;
  logic [3:0]  exp_rmask = '0;
  logic [3:0]  exp_wmask = '0;

  int      mon_got;
  int      mon_np;
  exp_ev_t mon_e;

  dmem_sched dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .ld_req(ld_req),
    .ld_idx(ld_idx),
    .ld_addr(ld_addr),
    .ld_rmask(ld_rmask),
    .st_req(st_req),
    .st_addr(st_addr),
    .st_wmask(st_wmask),
    .st_wdata(st_wdata),
    .ld_grant(ld_grant),
    .st_grant(st_grant),
    .dmem_addr(dmem_addr),
    .dmem_rmask(dmem_rmask),
    .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp),
    .ld_done(ld_done),
    .ld_done_idx(ld_done_idx),
    .ld_rdata(ld_rdata),
    .st_pop(st_pop),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic randomize_payload();
    pend_ld_idx   = IDXW'($urandom);
    pend_ld_addr  = $urandom;
    pend_ld_rmask = 4'($urandom);
    pend_st_addr  = $urandom;
    pend_st_wmask = 4'($urandom);
    pend_st_wdata = $urandom;
    pend_rdata    = $urandom;
  endtask

  // Drives one cycle of inputs and records what the memory stage must do.
  task automatic apply_stimulus(input bit st, input bit ld, input bit fl);
    exp_ev_t e;
    bit      resp;
    bit      ld_ok;
    @(posedge clk);
    #1;
    st_req   = st;
    ld_req   = ld;
    flush    = fl;
    ld_idx   = pend_ld_idx;
    ld_addr  = pend_ld_addr;
    ld_rmask = pend_ld_rmask;
    st_addr  = pend_st_addr;
    st_wmask = pend_st_wmask;
    st_wdata = pend_st_wdata;
    resp = ((m_kind != 0) && (m_age >= lat)) || spurious_resp;
    dmem_resp  = resp;
    dmem_rdata = pend_rdata;
    exp_busy  = (m_kind != 0);
    exp_addr  = m_addr;
    exp_rmask = (m_kind == 1) ? m_rmask : 4'h0;
    exp_wmask = (m_kind == 2) ? m_wmask : 4'h0;
    exp_wdata = (m_kind == 2) ? m_wdata : 32'h0;
    mon_en = 1'b1;
    e.kind = 0;
    e.cyc  = cycle;
    e.idx  = '0;
    e.data = '0;
    if (m_kind == 0) begin
      ld_ok = ld && !fl && (!st || (m_starve == LIMIT));
      if (ld_ok) begin
        e.kind = K_LDG;
        exp_q.push_back(e);
        m_kind = 1;
        m_addr = pend_ld_addr;
        m_rmask = pend_ld_rmask;
        m_idx = pend_ld_idx;
        m_squash = 1'b0;
        m_age = 0;
        m_starve = 0;
      end else if (st) begin
        e.kind = K_STG;
        exp_q.push_back(e);
        m_kind = 2;
        m_addr = pend_st_addr;
        m_wmask = pend_st_wmask;
        m_wdata = pend_st_wdata;
        m_age = 0;
        m_starve = ld ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
      end else if (!ld) begin
        m_starve = 0;
      end
    end else if (m_kind == 1) begin
      if (resp) begin
        if (!fl && !m_squash) begin
          e.kind = K_DONE;
          e.idx  = 32'(m_idx);
          e.data = pend_rdata;
          exp_q.push_back(e);
        end
        m_kind = 0;
      end else if (fl) begin
        m_squash = 1'b1;
      end
    end else begin
      if (resp) begin
        e.kind = K_POP;
        exp_q.push_back(e);
        m_kind = 0;
      end
    end
    if (m_kind != 0) m_age++;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_ld_grant"}, 32'(ld_grant), 32'h0);
    check_output({tag, "_st_grant"}, 32'(st_grant), 32'h0);
    check_output({tag, "_ld_done"}, 32'(ld_done), 32'h0);
    check_output({tag, "_ld_done_idx"}, 32'(ld_done_idx), 32'h0);
    check_output({tag, "_ld_rdata"}, ld_rdata, 32'h0);
    check_output({tag, "_st_pop"}, 32'(st_pop), 32'h0);
    check_output({tag, "_busy"}, 32'(busy), 32'h0);
    check_output({tag, "_dmem_addr"}, dmem_addr, 32'h0);
    check_output({tag, "_dmem_rmask"}, 32'(dmem_rmask), 32'h0);
    check_output({tag, "_dmem_wmask"}, 32'(dmem_wmask), 32'h0);
    check_output({tag, "_dmem_wdata"}, dmem_wdata, 32'h0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_kind = 0;
    m_age = 0;
    m_squash = 1'b0;
    m_starve = 0;
    m_addr = '0;
    m_wdata = '0;
    m_rmask = '0;
    m_wmask = '0;
    m_idx = '0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    st_req = 1'b0;
    ld_req = 1'b0;
    flush = 1'b0;
    dmem_resp = 1'b0;
    exp_busy = 1'b0;
    exp_rmask = '0;
    exp_wmask = '0;
    mon_en = 1'b1;
  endtask

  // Reset lands asynchronously partway through a cycle, then dmem_resp arrives.
  task automatic reset_mid_cycle();
    @(posedge clk);
    #2;
    rst = 1'b0;
    mon_en = 1'b0;
    #1;
    check_all_zero("rst_async");
    dmem_resp = 1'b1;
    #1;
    check_all_zero("rst_resp");
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    release_reset();
  endtask

  always @(negedge clk) begin
    if (rst && mon_en) begin
      mon_np = int'(ld_grant) + int'(st_grant) + int'(ld_done) + int'(st_pop);
      check_output("pulse_exclusive", 32'(mon_np <= 1), 32'h1);
      mon_got = ld_grant ? K_LDG : st_grant ? K_STG : ld_done ? K_DONE : st_pop ? K_POP : 0;
      if (mon_got != 0) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_event", mon_got, 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          check_output("event_kind", mon_got, mon_e.kind);
          check_output("event_cycle", cycle, mon_e.cyc);
          if (mon_got == K_DONE) begin
            check_output("ld_done_idx", 32'(ld_done_idx), mon_e.idx);
            check_output("ld_rdata", ld_rdata, mon_e.data);
          end
        end
      end else if ((exp_q.size() != 0) && (exp_q[0].cyc <= cycle)) begin
        mon_e = exp_q.pop_front();
        check_output("missed_event", 32'h0, mon_e.kind);
      end
      if (!ld_done) begin
        check_output("idle_done_idx", 32'(ld_done_idx), 32'h0);
        check_output("idle_rdata", ld_rdata, 32'h0);
      end
      check_output("busy", 32'(busy), 32'(exp_busy));
      check_output("dmem_rmask", 32'(dmem_rmask), 32'(exp_rmask));
      check_output("dmem_wmask", 32'(dmem_wmask), 32'(exp_wmask));
      if (exp_busy) begin
        check_output("dmem_addr", dmem_addr, exp_addr);
        check_output("dmem_wdata", dmem_wdata, exp_wdata);
      end
    end
  end

  initial begin
    $display("[TB] starting dmem_sched bench");
    st_req = 1'b1;
    ld_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    release_reset();

    // Store only, response three cycles after grant.
    lat = 3;
    pend_st_addr = 32'h100;
    pend_st_wmask = 4'hF;
    pend_st_wdata = 32'h1234_5678;
    apply_stimulus(1'b1, 1'b0, 1'b0);
    repeat (4) apply_stimulus(1'b0, 1'b0, 1'b0);

    // Load only.
    lat = 2;
    pend_ld_idx = 3'd5;
    pend_ld_addr = 32'h200;
    pend_ld_rmask = 4'hF;
    pend_rdata = 32'hDEAD_BEEF;
    apply_stimulus(1'b0, 1'b1, 1'b0);
    repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0);

    // Starvation: four stores, then the forced load, then stores again.
    lat = 1;
    repeat (16) apply_stimulus(1'b1, 1'b1, 1'b0);
    repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0);

    // Flush in LD_WAIT, response two cycles later.
    lat = 3;
    apply_stimulus(1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0);

    // Flush during ST_WAIT, then flush with only a load pending in IDLE.
    lat = 2;
    apply_stimulus(1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0);

    // Flush coinciding with the load response.
    lat = 2;
    apply_stimulus(1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0);

    // Reset in ST_WAIT; the late response must be ignored.
    lat = 6;
    apply_stimulus(1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    reset_mid_cycle();
    spurious_resp = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0);
    spurious_resp = 1'b0;
    lat = 1;
    apply_stimulus(1'b1, 1'b0, 1'b0);
    repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0);

    repeat (2000) begin
      randomize_payload();
      if (m_kind == 0) lat = $urandom_range(1, 4);
      apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
    end
    repeat (8) apply_stimulus(1'b0, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    check_output("queue_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
